// File: rtl/morra_cinese.sv
// Rock-paper-scissors ("morra cinese") game referee.
// Each PLAY cycle judges one manche; MANCHE/PARTITA are Mealy outputs that
// reflect the inputs applied in the same cycle. A RESTART configures a new
// game of 4..19 manches. A player who wins a manche may not repeat the
// winning move in the next manche.
module morra_cinese (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       INIZIA,
   input  logic [1:0] PRIMO,
   input  logic [1:0] SECONDO,
   output logic [1:0] MANCHE,
   output logic [1:0] PARTITA,
   output logic [4:0] max_manches,
   output logic [4:0] manches_played,
   output logic [4:0] current_state,
   output logic [4:0] next_state,
   output logic       moves_are_valid,
   output logic       played_max,
   output logic       played_min,
   output logic [1:0] early_winner,
   output logic [1:0] tmp_game_winner,
   output logic [1:0] last_p1_move,
   output logic [1:0] last_p2_move
);

   localparam logic [4:0] S_IDLE = 5'b00000;
   localparam logic [4:0] S_PLAY = 5'b00001;
   localparam logic [4:0] S_END  = 5'b00010;

   logic [4:0] p1_wins;
   logic [4:0] p2_wins;
   logic [4:0] played_upd;
   logic [4:0] p1_upd;
   logic [4:0] p2_upd;
   logic [1:0] manche_res;
   logic [1:0] game_res;
   logic       p1_beats;
   logic       manche_ok;

   // A move pair is legal when both players moved and nobody repeats a forbidden move.
   always_comb begin
      moves_are_valid = (PRIMO != 2'b00) && (SECONDO != 2'b00)
                        && ((last_p1_move == 2'b00) || (PRIMO != last_p1_move))
                        && ((last_p2_move == 2'b00) || (SECONDO != last_p2_move));
      manche_ok = !INIZIA && (current_state == S_PLAY) && moves_are_valid;
   end

   // Manche winner: paper beats rock, rock beats scissors, scissors beats paper.
   always_comb begin
      p1_beats = ((PRIMO == 2'b10) && (SECONDO == 2'b01))
              || ((PRIMO == 2'b01) && (SECONDO == 2'b11))
              || ((PRIMO == 2'b11) && (SECONDO == 2'b10));
      if (PRIMO == SECONDO)
         manche_res = 2'b11;
      else if (p1_beats)
         manche_res = 2'b01;
      else
         manche_res = 2'b10;
   end

   // Game-end evaluation on counts that already include the current manche.
   always_comb begin
      played_upd = manches_played + 5'd1;
      p1_upd     = p1_wins + {4'b0000, (manche_res == 2'b01)};
      p2_upd     = p2_wins + {4'b0000, (manche_res == 2'b10)};
      played_min = (played_upd >= 5'd4);
      played_max = (played_upd == max_manches);
      if ({1'b0, p1_upd} >= ({1'b0, p2_upd} + 6'd2))
         early_winner = 2'b01;
      else if ({1'b0, p2_upd} >= ({1'b0, p1_upd} + 6'd2))
         early_winner = 2'b10;
      else
         early_winner = 2'b00;
      if (p1_upd > p2_upd)
         tmp_game_winner = 2'b01;
      else if (p2_upd > p1_upd)
         tmp_game_winner = 2'b10;
      else
         tmp_game_winner = 2'b11;
      game_res = 2'b00;
      if (manche_ok) begin
         if (played_min && (early_winner != 2'b00))
            game_res = early_winner;
         else if (played_max)
            game_res = tmp_game_winner;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         current_state <= S_IDLE;
      else
         current_state <= next_state;
   end

   // Next state: RESTART always enters PLAY; a decided game moves to END.
   always_comb begin
      next_state = current_state;
      if (INIZIA)
         next_state = S_PLAY;
      else if (manche_ok && (game_res != 2'b00))
         next_state = S_END;
   end

   // Mealy outputs: only a legal manche in PLAY produces a result.
   always_comb begin
      MANCHE  = 2'b00;
      PARTITA = 2'b00;
      if (manche_ok) begin
         MANCHE  = manche_res;
         PARTITA = game_res;
      end
   end

   // Game progress registers: configured on RESTART, updated on legal manches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_manches    <= 5'd0;
         manches_played <= 5'd0;
         p1_wins        <= 5'd0;
         p2_wins        <= 5'd0;
         last_p1_move   <= 2'b00;
         last_p2_move   <= 2'b00;
      end else if (INIZIA) begin
         max_manches    <= {1'b0, PRIMO, SECONDO} + 5'd4;
         manches_played <= 5'd0;
         p1_wins        <= 5'd0;
         p2_wins        <= 5'd0;
         last_p1_move   <= 2'b00;
         last_p2_move   <= 2'b00;
      end else if (manche_ok) begin
         manches_played <= played_upd;
         p1_wins        <= p1_upd;
         p2_wins        <= p2_upd;
         case (manche_res)
            2'b01: begin
               last_p1_move <= PRIMO;
               last_p2_move <= 2'b00;
            end
            2'b10: begin
               last_p1_move <= 2'b00;
               last_p2_move <= SECONDO;
            end
            default: begin
               last_p1_move <= 2'b00;
               last_p2_move <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_morra_cinese.sv
// Testbench for morra_cinese: directed game scenarios plus a random run
// against a reference model. MANCHE/PARTITA expectations go through a queue.
module tb_morra_cinese;

   // Clock and reset
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       INIZIA = 1'b0;
   logic [1:0] PRIMO = 2'b00;
   logic [1:0] SECONDO = 2'b00;
   logic [1:0] MANCHE, PARTITA;
   logic [4:0] max_manches, manches_played, current_state, next_state;
   logic       moves_are_valid, played_max, played_min;
   logic [1:0] early_winner, tmp_game_winner, last_p1_move, last_p2_move;

   always #5 clk = ~clk;

   morra_cinese dut (
      .clk(clk), .rst_n(rst_n), .INIZIA(INIZIA), .PRIMO(PRIMO), .SECONDO(SECONDO),
      .MANCHE(MANCHE), .PARTITA(PARTITA),
      .max_manches(max_manches), .manches_played(manches_played),
      .current_state(current_state), .next_state(next_state),
      .moves_are_valid(moves_are_valid), .played_max(played_max), .played_min(played_min),
      .early_winner(early_winner), .tmp_game_winner(tmp_game_winner),
      .last_p1_move(last_p1_move), .last_p2_move(last_p2_move)
   );

   localparam logic [1:0] NO = 2'b00, RO = 2'b01, PA = 2'b10, SC = 2'b11;
   localparam logic [4:0] ST_IDLE = 5'd0, ST_PLAY = 5'd1, ST_END = 5'd2;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q[$];
   string cur_tag = "";
   event sample_ev;

   // Scoreboard: pop the expected {MANCHE,PARTITA} whenever a step is sampled
   always @(sample_ev) begin
      logic [3:0] exp_v;
      logic [3:0] got_v;
      got_v = {MANCHE, PARTITA};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: output %b sampled with no expectation queued", cur_tag, got_v);
      end else begin
         exp_v = exp_q.pop_front();
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: MANCHE/PARTITA got %b_%b expected %b_%b",
                     cur_tag, got_v[3:2], got_v[1:0], exp_v[3:2], exp_v[1:0]);
         end
      end
   end

   // Driver tasks: inputs change on the falling edge, outputs sampled 1ns later
   task automatic drive_play(input logic [1:0] p1, input logic [1:0] p2,
                             input logic [1:0] em, input logic [1:0] ep, input string tag);
      @(negedge clk);
      INIZIA = 1'b0;
      PRIMO = p1;
      SECONDO = p2;
      exp_q.push_back({em, ep});
      cur_tag = tag;
      #1 -> sample_ev;
   endtask

   task automatic drive_restart(input logic [3:0] cfg, input string tag);
      @(negedge clk);
      INIZIA = 1'b1;
      PRIMO = cfg[3:2];
      SECONDO = cfg[1:0];
      exp_q.push_back(4'b0000);
      cur_tag = tag;
      #1 -> sample_ev;
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      INIZIA = 1'b0; PRIMO = RO; SECONDO = PA;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (current_state !== ST_IDLE || max_manches !== 5'd0 || manches_played !== 5'd0) begin
         errors++;
         $display("FAIL reset_regs: state %0d max %0d played %0d expected 0 0 0",
                  current_state, max_manches, manches_played);
      end
      checks++;
      if ({MANCHE, PARTITA} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_out: got %b expected 0000", {MANCHE, PARTITA});
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive_play(RO, PA, 2'b00, 2'b00, "idle_ignores_play");
      drive_play(SC, RO, 2'b00, 2'b00, "idle_ignores_play2");
      settle();
      checks++;
      if (current_state !== ST_IDLE || manches_played !== 5'd0) begin
         errors++;
         $display("FAIL idle_hold: state %0d played %0d expected 0 0", current_state, manches_played);
      end
   endtask

   task automatic test_forbidden();
      drive_restart(4'b1001, "fb_restart");
      settle();
      checks++;
      if (max_manches !== 5'd13 || current_state !== ST_PLAY) begin
         errors++;
         $display("FAIL fb_config: max %0d state %0d expected 13 1", max_manches, current_state);
      end
      drive_play(NO, NO, 2'b00, 2'b00, "fb_none_none");
      drive_play(PA, RO, 2'b01, 2'b00, "fb_paper_rock");
      drive_play(SC, RO, 2'b10, 2'b00, "fb_scissors_rock");
      drive_play(NO, PA, 2'b00, 2'b00, "fb_none_paper");
      drive_play(RO, RO, 2'b00, 2'b00, "fb_p2_repeat1");
      drive_play(RO, RO, 2'b00, 2'b00, "fb_p2_repeat2");
      drive_play(PA, RO, 2'b00, 2'b00, "fb_paper_rock_forbidden");
      settle();
      checks++;
      if (manches_played !== 5'd2 || last_p1_move !== NO || last_p2_move !== RO) begin
         errors++;
         $display("FAIL fb_regs: played %0d last %b/%b expected 2 00/01",
                  manches_played, last_p1_move, last_p2_move);
      end
   endtask

   task automatic test_early_end();
      drive_restart(4'b0001, "ee_restart");
      drive_play(RO, PA, 2'b10, 2'b00, "ee_m1");
      drive_play(SC, RO, 2'b10, 2'b00, "ee_m2");
      drive_play(PA, SC, 2'b10, 2'b00, "ee_m3");
      drive_play(SC, PA, 2'b01, 2'b10, "ee_m4_end");
      settle();
      checks++;
      if (current_state !== ST_END || manches_played !== 5'd4) begin
         errors++;
         $display("FAIL ee_state: state %0d played %0d expected 2 4", current_state, manches_played);
      end
   endtask

   task automatic test_draws();
      drive_restart(4'b0001, "dr_restart");
      drive_play(SC, SC, 2'b11, 2'b00, "dr_draw1");
      drive_play(SC, SC, 2'b11, 2'b00, "dr_draw2");
      drive_play(SC, RO, 2'b10, 2'b00, "dr_m3");
      drive_play(PA, SC, 2'b10, 2'b10, "dr_m4_end");
      settle();
      checks++;
      if (current_state !== ST_END || manches_played !== 5'd4) begin
         errors++;
         $display("FAIL dr_state: state %0d played %0d expected 2 4", current_state, manches_played);
      end
   endtask

   task automatic test_max_tie();
      drive_restart(4'b0001, "mt_restart");
      settle();
      checks++;
      if (max_manches !== 5'd5) begin
         errors++;
         $display("FAIL mt_config: max %0d expected 5", max_manches);
      end
      drive_play(SC, SC, 2'b11, 2'b00, "mt_draw1");
      drive_play(SC, SC, 2'b11, 2'b00, "mt_draw2");
      drive_play(SC, SC, 2'b11, 2'b00, "mt_draw3");
      drive_play(SC, RO, 2'b10, 2'b00, "mt_m4");
      drive_play(RO, SC, 2'b01, 2'b11, "mt_m5_tie");
      settle();
      checks++;
      if (current_state !== ST_END || manches_played !== 5'd5) begin
         errors++;
         $display("FAIL mt_state: state %0d played %0d expected 2 5", current_state, manches_played);
      end
   endtask

   task automatic test_after_end();
      drive_play(RO, PA, 2'b00, 2'b00, "ae_ignored1");
      drive_play(PA, SC, 2'b00, 2'b00, "ae_ignored2");
      settle();
      checks++;
      if (current_state !== ST_END || manches_played !== 5'd5) begin
         errors++;
         $display("FAIL ae_hold: state %0d played %0d expected 2 5", current_state, manches_played);
      end
      drive_restart(4'b0011, "ae_restart");
      settle();
      checks++;
      if (current_state !== ST_PLAY || manches_played !== 5'd0 || max_manches !== 5'd7) begin
         errors++;
         $display("FAIL ae_restart_regs: state %0d played %0d max %0d expected 1 0 7",
                  current_state, manches_played, max_manches);
      end
      drive_play(PA, RO, 2'b01, 2'b00, "ae_play_again");
   endtask

   task automatic test_midgame_reset();
      @(negedge clk);
      #2;
      INIZIA = 1'b0; PRIMO = SC; SECONDO = PA;
      rst_n = 1'b0;
      #1;
      checks++;
      if (current_state !== ST_IDLE || max_manches !== 5'd0 || manches_played !== 5'd0
          || last_p1_move !== NO) begin
         errors++;
         $display("FAIL mr_regs: state %0d max %0d played %0d last1 %b expected 0 0 0 00",
                  current_state, max_manches, manches_played, last_p1_move);
      end
      checks++;
      if ({MANCHE, PARTITA} !== 4'b0000) begin
         errors++;
         $display("FAIL mr_out: got %b expected 0000", {MANCHE, PARTITA});
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive_play(PA, RO, 2'b00, 2'b00, "mr_ignored");
      settle();
      checks++;
      if (current_state !== ST_IDLE || manches_played !== 5'd0) begin
         errors++;
         $display("FAIL mr_idle: state %0d played %0d expected 0 0", current_state, manches_played);
      end
      drive_restart(4'b0000, "mr_restart");
      drive_play(RO, SC, 2'b01, 2'b00, "mr_play");
      settle();
      checks++;
      if (current_state !== ST_PLAY || max_manches !== 5'd4 || manches_played !== 5'd1) begin
         errors++;
         $display("FAIL mr_resume: state %0d max %0d played %0d expected 1 4 1",
                  current_state, max_manches, manches_played);
      end
   endtask

   // Random games checked against an independent model of the rules
   task automatic test_random();
      int m_state, m_max, m_played, m_w1, m_w2, m_l1, m_l2;
      int p1, p2, res, par, early;
      bit valid;
      logic [3:0] cfg;
      cfg = 4'($urandom_range(0, 3));
      drive_restart(cfg, "rnd_restart0");
      m_state = 1; m_max = int'(cfg) + 4; m_played = 0; m_w1 = 0; m_w2 = 0; m_l1 = 0; m_l2 = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            cfg = 4'($urandom_range(0, 15));
            drive_restart(cfg, "rnd_restart");
            m_state = 1; m_max = int'(cfg) + 4; m_played = 0; m_w1 = 0; m_w2 = 0;
            m_l1 = 0; m_l2 = 0;
         end else begin
            p1 = $urandom_range(0, 3);
            p2 = $urandom_range(0, 3);
            valid = (m_state == 1) && p1 != 0 && p2 != 0 && (m_l1 == 0 || p1 != m_l1)
                    && (m_l2 == 0 || p2 != m_l2);
            res = 0; par = 0;
            if (valid) begin
               if (p1 == p2) res = 3;
               else if (((p1 - p2 + 3) % 3) == 1) res = 1;
               else res = 2;
               m_played++;
               if (res == 1) m_w1++;
               if (res == 2) m_w2++;
               early = (m_w1 - m_w2 >= 2) ? 1 : ((m_w2 - m_w1 >= 2) ? 2 : 0);
               if (m_played >= 4 && early != 0) par = early;
               else if (m_played == m_max) par = (m_w1 > m_w2) ? 1 : ((m_w2 > m_w1) ? 2 : 3);
               if (par != 0) m_state = 2;
               m_l1 = (res == 1) ? p1 : 0;
               m_l2 = (res == 2) ? p2 : 0;
            end
            drive_play(2'(p1), 2'(p2), 2'(res), 2'(par), "rnd_play");
         end
         settle();
         checks++;
         if (current_state !== 5'(m_state) || manches_played !== 5'(m_played)) begin
            errors++;
            $display("FAIL rnd_regs step %0d: state %0d played %0d expected %0d %0d",
                     i, current_state, manches_played, m_state, m_played);
         end
      end
   endtask

   initial begin
      test_reset();
      test_forbidden();
      test_early_end();
      test_draws();
      test_max_tie();
      test_after_end();
      test_midgame_reset();
      test_random();
      repeat (2) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
